decode_sequencer: RTL and testbench

- Sits between the instruction-fetch bus interface and the instruction decoder.
- Accepts 64-bit fetch beats, each holding two packed 32-bit RISC-V instructions with the low half first. Presents the instructions one at a time, in program order, to the decoder through a valid/ready handshake.
- Tracks the PC of each presented instruction, counts retired-to-decode instructions, and halts on an all-zero instruction word.

---
 rtl/decode_sequencer_if.sv | 26 ++
 rtl/decode_sequencer.sv | 153 +++++++++++++++
 tb/tb_decode_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_sequencer_if.sv
// Handshake bundle between fetch bus, decode_sequencer and the instruction decoder.
// Ports: fetch_valid/fetch_data/fetch_ready (fetch beats in), inst_valid/inst/inst_pc/inst_ready (instructions out).
// master = the sequencer side; slave = the surrounding fetch unit and decoder.
interface decode_sequencer_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int INST_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 64
);
  logic                      fetch_valid;
  logic [BUS_DATA_WIDTH-1:0] fetch_data;
  logic                      fetch_ready;
  logic                      inst_valid;
  logic [INST_WIDTH-1:0]     inst;
  logic [ADDR_WIDTH-1:0]     inst_pc;
  logic                      inst_ready;

  modport master (
    input  fetch_valid, fetch_data, inst_ready,
    output fetch_ready, inst_valid, inst, inst_pc
  );

  modport slave (
    output fetch_valid, fetch_data, inst_ready,
    input  fetch_ready, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/decode_sequencer.sv
// Splits 64-bit fetch beats into two 32-bit instructions presented in program order with their PC.
// Latency: beat accepted at edge N -> inst_valid in cycle N+1; 2 instructions per 3 cycles unstalled.
// Backpressure: inst held stable while inst_ready=0; fetch_ready only asserted once both halves are consumed.
// Ports: clk, reset (sync, active-high), start/entry_pc (begin sequencing), bus (decode_sequencer_if.master),
//        halted (zero instruction seen, terminal until reset), inst_count (saturating count of handed-off instructions).
module decode_sequencer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int INST_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 64,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  entry_pc,
  decode_sequencer_if.master     bus,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] inst_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] INST_BYTES = ADDR_WIDTH'(INST_WIDTH / 8);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  skip_low;
  // Only the upper half of a beat needs holding: the lower half is loaded
  // straight into the output register when the beat is accepted.
  logic [INST_WIDTH-1:0] hi_buf;

  logic                  fetch_ready_r;
  logic                  inst_valid_r;
  logic [INST_WIDTH-1:0] inst_r;
  logic [ADDR_WIDTH-1:0] inst_pc_r;

  logic [INST_WIDTH-1:0]  lo_word;
  logic [INST_WIDTH-1:0]  hi_word;
  logic [ADDR_WIDTH-1:0]  pc_next;
  logic [COUNT_WIDTH-1:0] count_next;

  assign lo_word    = bus.fetch_data[INST_WIDTH-1:0];
  assign hi_word    = bus.fetch_data[BUS_DATA_WIDTH-1:INST_WIDTH];
  assign pc_next    = pc + INST_BYTES;
  assign count_next = (inst_count == '1) ? inst_count : inst_count + COUNT_WIDTH'(1);

  assign bus.fetch_ready = fetch_ready_r;
  assign bus.inst_valid  = inst_valid_r;
  assign bus.inst        = inst_r;
  assign bus.inst_pc     = inst_pc_r;

  // Every output is a register updated alongside the state transition that
  // changes it, so outputs never depend combinationally on inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= '0;
      skip_low      <= 1'b0;
      hi_buf        <= '0;
      fetch_ready_r <= 1'b0;
      inst_valid_r  <= 1'b0;
      inst_r        <= '0;
      inst_pc_r     <= '0;
      halted        <= 1'b0;
      inst_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc            <= entry_pc;
            // An entry PC in the upper half of a beat means the lower half
            // of the first beat precedes the entry point and is dropped.
            skip_low      <= entry_pc[2];
            state         <= FETCH;
            fetch_ready_r <= 1'b1;
          end
        end

        FETCH: begin
          if (bus.fetch_valid) begin
            hi_buf        <= hi_word;
            fetch_ready_r <= 1'b0;
            skip_low      <= 1'b0;
            if (skip_low) begin
              if (hi_word == '0) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                state        <= HIGH;
                inst_valid_r <= 1'b1;
                inst_r       <= hi_word;
                inst_pc_r    <= pc;
              end
            end else if (lo_word == '0) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state        <= LOW;
              inst_valid_r <= 1'b1;
              inst_r       <= lo_word;
              inst_pc_r    <= pc;
            end
          end
        end

        LOW: begin
          if (bus.inst_ready) begin
            pc         <= pc_next;
            inst_count <= count_next;
            if (hi_buf == '0) begin
              state        <= HALT;
              halted       <= 1'b1;
              inst_valid_r <= 1'b0;
              inst_r       <= '0;
              inst_pc_r    <= '0;
            end else begin
              state     <= HIGH;
              inst_r    <= hi_buf;
              inst_pc_r <= pc_next;
            end
          end
        end

        HIGH: begin
          if (bus.inst_ready) begin
            pc            <= pc_next;
            inst_count    <= count_next;
            state         <= FETCH;
            inst_valid_r  <= 1'b0;
            inst_r        <= '0;
            inst_pc_r     <= '0;
            fetch_ready_r <= 1'b1;
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: directed scenarios plus randomized beats and backpressure.
// Expected instructions come from a word-level model of the beat stream, checked by an independent monitor.
// Ports: drives clk/reset/start/entry_pc and the slave side of decode_sequencer_if.
module tb_decode_sequencer;

  typedef struct packed {
    logic [31:0] w;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] entry_pc;
  logic        halted;
  logic [31:0] inst_count;

  decode_sequencer_if bus ();

  decode_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .entry_pc   (entry_pc),
    .bus        (bus),
    .halted     (halted),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] exp_count;
  logic [63:0] mdl_pc;
  logic        mdl_skip;
  logic        mdl_halted;
  int          rdy_mode;   // 0: always ready, 1: random, 2: never, 3: driven by test code

  localparam logic [63:0] PAIR = 64'h00100093_00A00513;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Word-level view of one accepted beat: walk its halves in address order,
  // dropping the pre-entry half of the first beat, stopping at a zero word.
  task automatic model_beat(input logic [63:0] d);
    logic [31:0] words [2];
    words[0] = d[31:0];
    words[1] = d[63:32];
    for (int k = (mdl_skip ? 1 : 0); k < 2; k++) begin
      if (words[k] == 32'd0) begin
        mdl_halted = 1'b1;
        break;
      end
      exp_q.push_back('{w: words[k], pc: mdl_pc});
      mdl_pc = mdl_pc + 64'd4;
    end
    mdl_skip = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset           = 1'b1;
    start           = 1'b0;
    bus.fetch_valid = 1'b0;
    exp_q.delete();
    exp_count  = '0;
    mdl_pc     = '0;
    mdl_skip   = 1'b0;
    mdl_halted = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [63:0] pc);
    @(posedge clk); #1;
    start      = 1'b1;
    entry_pc   = pc;
    mdl_pc     = pc;
    mdl_skip   = pc[2];
    mdl_halted = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at #1 after the edge on which the beat was accepted.
  task automatic send_beat(input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.fetch_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      model_beat(d);
    end else begin
      checks++;
      failures++;
      $display("FAIL fetch_accept actual=no fetch_ready required=accept within 200 cycles t=%0t", $time);
    end
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_drained"}, 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    chk({name, "_halted"}, 64'(halted), 64'(mdl_halted));
    chk({name, "_fetch_ready"}, 64'(bus.fetch_ready), 64'(!mdl_halted));
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    chk({name, "_fetch_ready"}, 64'(bus.fetch_ready), 64'd0);
    chk({name, "_inst_valid"}, 64'(bus.inst_valid), 64'd0);
    chk({name, "_inst"}, 64'(bus.inst), 64'd0);
    chk({name, "_inst_pc"}, bus.inst_pc, 64'd0);
    chk({name, "_halted"}, 64'(halted), 64'd0);
    chk({name, "_inst_count"}, 64'(inst_count), 64'd0);
  endtask

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 11) == 0) return 32'd0;
    return $urandom | 32'd1;
  endfunction

  // Decoder-side ready generation.
  initial begin
    bus.inst_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.inst_ready = 1'b1;
        1: bus.inst_ready = ($urandom_range(0, 2) != 0);
        2: bus.inst_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Monitor: compares every handshake against the scoreboard queue, tracks
  // the expected count, and checks hold-stability and idle-zero outputs.
  initial begin
    exp_t        e;
    bit          hold;
    logic [31:0] hold_inst;
    logic [63:0] hold_pc;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
        continue;
      end
      chk("inst_count", 64'(inst_count), 64'(exp_count));
      if (hold) begin
        chk("stall_valid", 64'(bus.inst_valid), 64'd1);
        chk("stall_inst", 64'(bus.inst), 64'(hold_inst));
        chk("stall_pc", bus.inst_pc, hold_pc);
      end
      hold = 1'b0;
      if (!bus.inst_valid) begin
        chk("idle_inst_zero", 64'(bus.inst), 64'd0);
        chk("idle_pc_zero", bus.inst_pc, 64'd0);
      end else if (bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst actual=%h@%h required=no instruction t=%0t",
                   bus.inst, bus.inst_pc, $time);
        end else begin
          e = exp_q.pop_front();
          chk("inst", 64'(bus.inst), 64'(e.w));
          chk("inst_pc", bus.inst_pc, e.pc);
          if (exp_count != '1) exp_count = exp_count + 32'd1;
        end
      end else begin
        hold      = 1'b1;
        hold_inst = bus.inst;
        hold_pc   = bus.inst_pc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    entry_pc        = '0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
    rdy_mode        = 0;
    exp_q.delete();
    exp_count  = '0;
    mdl_pc     = '0;
    mdl_skip   = 1'b0;
    mdl_halted = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("por");

    // Basic pair with fetch_ready returning in the third cycle after the beat.
    do_reset();
    do_start(64'h1000);
    rdy_mode = 0;
    send_beat(PAIR);
    @(negedge clk);
    chk("pair_fr_c1", 64'(bus.fetch_ready), 64'd0);
    @(negedge clk);
    chk("pair_fr_c2", 64'(bus.fetch_ready), 64'd0);
    @(negedge clk);
    chk("pair_fr_c3", 64'(bus.fetch_ready), 64'd1);
    chk("pair_count", 64'(inst_count), 64'd2);
    drain("pair");

    // Backpressure: four stalled cycles, then exactly one handshake.
    do_reset();
    do_start(64'h1000);
    rdy_mode = 2;
    send_beat(PAIR);
    repeat (4) begin
      @(negedge clk);
      chk("bp_inst", 64'(bus.inst), 64'h00A00513);
      chk("bp_pc", bus.inst_pc, 64'h1000);
      chk("bp_count", 64'(inst_count), 64'd0);
    end
    rdy_mode = 2;
    @(posedge clk); #1;
    rdy_mode = 3;
    bus.inst_ready = 1'b1;
    @(posedge clk); #1;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    chk("bp_count_release", 64'(inst_count), 64'd1);
    chk("bp_next_pc", bus.inst_pc, 64'h1004);
    rdy_mode = 0;
    drain("bp");

    // Zero halt; later start and beats are ignored.
    do_reset();
    do_start(64'h1000);
    rdy_mode = 0;
    send_beat(64'h00000000_00A00513);
    repeat (3) @(negedge clk);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_fetch_ready", 64'(bus.fetch_ready), 64'd0);
    chk("halt_count", 64'(inst_count), 64'd1);
    @(posedge clk); #1;
    start           = 1'b1;
    entry_pc        = 64'h5000;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = PAIR;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("halt_stay_fr", 64'(bus.fetch_ready), 64'd0);
      chk("halt_stay_valid", 64'(bus.inst_valid), 64'd0);
      chk("halt_stay_halted", 64'(halted), 64'd1);
      chk("halt_stay_count", 64'(inst_count), 64'd1);
    end
    bus.fetch_valid = 1'b0;
    drain("halt");

    // Misaligned entry drops the low half of the first beat only.
    do_reset();
    do_start(64'h1004);
    rdy_mode = 1;
    send_beat(PAIR);
    send_beat(64'h00000013_00000293);
    drain("misaligned");

    // Reset while HIGH is being presented, then resume from a new entry.
    do_reset();
    do_start(64'h1000);
    rdy_mode = 3;
    bus.inst_ready = 1'b0;
    send_beat(PAIR);
    bus.inst_ready = 1'b1;
    @(posedge clk); #1;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.inst_valid), 64'd1);
    chk("midrst_pc", bus.inst_pc, 64'h1004);
    do_reset();
    check_reset_outputs("midrst");
    do_start(64'h2000);
    rdy_mode = 0;
    send_beat(PAIR);
    drain("resume");

    // Stream of three back-to-back non-zero beats.
    do_reset();
    do_start(64'h1000);
    rdy_mode = 0;
    for (int b = 0; b < 3; b++) send_beat({$urandom | 32'd1, $urandom | 32'd1});
    drain("stream");
    chk("stream_count", 64'(inst_count), 64'd6);

    // Randomized rounds, the first one straddling the PC wrap.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      if (r == 0) do_start(64'hFFFF_FFFF_FFFF_FFF8);
      else        do_start({$urandom, $urandom} & ~64'h3);
      rdy_mode = 1;
      for (int b = 0; b < 8; b++) begin
        if (mdl_halted) break;
        send_beat({rand_word(), rand_word()});
      end
      drain("random");
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
